button_encoder_p1: RTL

Front-end conditioner for the brightness controller. It takes three raw, bouncy push-button inputs and produces the 2-bit command codes the brightness state machine consumes on its `up`, `down` and `toggle` inputs:
- `2'b01`: single-cycle press event.
- `2'b11`: single-cycle hold/auto-repeat event.
- `2'b00`: idle.

It performs synchronisation, debouncing, press/hold classification, auto-repeat and multi-button (chord) lockout.

---
 rtl/button_encoder_p1_if.sv | 20 ++
 rtl/button_encoder_p1.sv | 139 +++++++++++++
 2 files changed

// File: rtl/button_encoder_p1_if.sv
// Button-to-command bundle: raw push-button levels in, 2-bit command codes out.
// The encoder sits on the slave side; the button board / brightness FSM on the master side.
interface button_encoder_p1_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_toggle;
  logic [1:0] up;
  logic [1:0] down;
  logic [1:0] toggle;

  modport master (
    output btn_up, btn_down, btn_toggle,
    input  up, down, toggle
  );

  modport slave (
    input  btn_up, btn_down, btn_toggle,
    output up, down, toggle
  );
endinterface

// File: rtl/button_encoder_p1.sv
// Three-channel push-button conditioner: synchronise, debounce, classify press/hold,
// auto-repeat and lock out chords, producing registered 2-bit command codes.
module button_encoder_p1 #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic               clock,
  input  logic               reset,
  button_encoder_p1_if.slave bus
);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TM_W  = $clog2(TM_MAX + 1);

  localparam logic [DB_W-1:0] DB_LIMIT   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TM_W-1:0] HOLD_LIMIT = TM_W'(HOLD_CYCLES);
  localparam logic [TM_W-1:0] REP_LIMIT  = TM_W'(REPEAT_CYCLES);

  localparam logic [1:0] CODE_IDLE  = 2'b00;
  localparam logic [1:0] CODE_PRESS = 2'b01;
  localparam logic [1:0] CODE_HOLD  = 2'b11;

  typedef enum logic [1:0] {IDLE, PRESSED, REPEAT, LOCKED} state_t;

  logic [2:0]      raw;
  logic [2:0]      db;
  logic [2:0][1:0] code;
  logic            chord;

  // Channel order: 0 = up, 1 = down, 2 = toggle.
  assign raw   = {bus.btn_toggle, bus.btn_down, bus.btn_up};
  assign chord = (db[0] & db[1]) | (db[0] & db[2]) | (db[1] & db[2]);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic            sync1_reg;
      logic            sync2_reg;
      logic            db_reg;
      logic [DB_W-1:0] db_cnt_reg;
      state_t          state_reg;
      logic [TM_W-1:0] timer_reg;
      logic [TM_W-1:0] timer_inc;
      logic [1:0]      code_reg;

      assign timer_inc = timer_reg + TM_W'(1);
      assign db[gi]    = db_reg;
      assign code[gi]  = code_reg;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // A level is accepted only after it has disagreed with db for DEBOUNCE_CYCLES+1 samples.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          db_reg     <= 1'b0;
          db_cnt_reg <= '0;
        end else if (sync2_reg != db_reg) begin
          if (db_cnt_reg == DB_LIMIT) begin
            db_reg     <= ~db_reg;
            db_cnt_reg <= '0;
          end else begin
            db_cnt_reg <= db_cnt_reg + DB_W'(1);
          end
        end else begin
          db_cnt_reg <= '0;
        end
      end

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_reg <= IDLE;
          timer_reg <= '0;
          code_reg  <= CODE_IDLE;
        end else begin
          code_reg <= CODE_IDLE;
          // Chord lockout overrides everything, including a press rising this cycle.
          if (chord && db_reg) begin
            state_reg <= LOCKED;
            timer_reg <= '0;
          end else begin
            case (state_reg)
              IDLE: begin
                if (db_reg) begin
                  state_reg <= PRESSED;
                  timer_reg <= '0;
                  code_reg  <= CODE_PRESS;
                end
              end
              PRESSED: begin
                if (!db_reg) begin
                  state_reg <= IDLE;
                  timer_reg <= '0;
                end else if (timer_inc == HOLD_LIMIT) begin
                  state_reg <= REPEAT;
                  timer_reg <= '0;
                  code_reg  <= CODE_HOLD;
                end else begin
                  timer_reg <= timer_inc;
                end
              end
              REPEAT: begin
                if (!db_reg) begin
                  state_reg <= IDLE;
                  timer_reg <= '0;
                end else if (timer_inc == REP_LIMIT) begin
                  timer_reg <= '0;
                  code_reg  <= CODE_HOLD;
                end else begin
                  timer_reg <= timer_inc;
                end
              end
              LOCKED: begin
                if (!db_reg) begin
                  state_reg <= IDLE;
                end
              end
              default: begin
                state_reg <= IDLE;
                timer_reg <= '0;
              end
            endcase
          end
        end
      end
    end
  endgenerate

  assign bus.up     = code[0];
  assign bus.down   = code[1];
  assign bus.toggle = code[2];
endmodule
